// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the MUL_ARRAY arbiter: lane geometry, FSM states, index sizing.
package mul_arb_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned NLANE  = 9;
  localparam int unsigned M      = LANE_W * NLANE;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_e;

  // Width of an index into n items; a single item still gets one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arb_rr.sv
// Combinational round-robin picker: first masked request at or after rr_ptr, wrapping modulo NREQ.
module mul_arb_rr #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic [NREQ-1:0]  mask,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [NREQ-1:0] req_m;

  assign req_m = req & mask;

  always_comb begin
    int unsigned c;
    c       = 0;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = (32'(rr_ptr) + k) % NREQ;
      if (!any && req_m[c]) begin
        any     = 1'b1;
        win[c]  = 1'b1;
        win_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mul_array_arbiter.sv
// Round-robin arbiter sharing one 9-lane GF(2^16) MUL_ARRAY among NREQ clients, one op per grant.
// Define MUL_ARB_LOCK_EN to let a locked owner issue back-to-back ops without re-arbitration.
module mul_array_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned M       = mul_arb_pkg::M,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*M-1:0] opd_o_in,
  input  logic [NREQ*M-1:0] opd_t_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_vld,
  output logic [M-1:0]      rsp_dat,
  output logic [M-1:0]      mul_o_out,
  output logic [M-1:0]      mul_t_out,
  input  logic [M-1:0]      mul_r_dat
);
  import mul_arb_pkg::*;

  localparam int unsigned IDX_W = idx_w(NREQ);
  localparam int unsigned LAT_W = idx_w(MUL_LAT);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [M-1:0]      opd_o_q, opd_o_d, opd_t_q, opd_t_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, rsp_vld_q, rsp_vld_d;
  logic [M-1:0]      rsp_dat_q, rsp_dat_d;

  logic [NREQ-1:0]   own_oh, pick_mask, pick_win;
  logic [IDX_W-1:0]  pick_idx, next_ptr;
  logic              pick_any;
  int unsigned       src_idx;
  logic [M-1:0]      sel_o, sel_t;

  assign own_oh   = NREQ'(1) << owner_q;
  assign next_ptr = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // RESP only ever recaptures for the current owner; IDLE captures for the picked winner.
  assign src_idx  = (state_q == RESP) ? 32'(owner_q) : 32'(pick_idx);
  assign sel_o    = opd_o_in[src_idx*M +: M];
  assign sel_t    = opd_t_in[src_idx*M +: M];

`ifdef MUL_ARB_LOCK_EN
  logic hold_q, hold_d;
  logic lock_own, req_own;

  assign lock_own  = |(lock & own_oh);
  assign req_own   = |(req & own_oh);
  assign pick_mask = (hold_q && lock_own) ? own_oh : '1;
`else
  logic unused_lock;

  assign unused_lock = ^lock;
  assign pick_mask   = '1;
`endif

  mul_arb_rr #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .mask    (pick_mask),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    opd_o_d   = opd_o_q;
    opd_t_d   = opd_t_q;
    gnt_d     = '0;
    rsp_vld_d = '0;
    rsp_dat_d = rsp_dat_q;
`ifdef MUL_ARB_LOCK_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef MUL_ARB_LOCK_EN
        if (hold_q && !lock_own) hold_d = 1'b0;
`endif
        if (pick_any) begin
          opd_o_d   = sel_o;
          opd_t_d   = sel_t;
          gnt_d     = pick_win;
          owner_d   = pick_idx;
          lat_cnt_d = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        lat_cnt_d = lat_cnt_q + LAT_W'(1);
        if (lat_cnt_q == LAT_W'(MUL_LAT - 1)) begin
          rsp_dat_d = mul_r_dat;
          rsp_vld_d = own_oh;
          state_d   = RESP;
        end
      end
      RESP: begin
        opd_o_d  = '0;
        opd_t_d  = '0;
        rr_ptr_d = next_ptr;
        state_d  = IDLE;
`ifdef MUL_ARB_LOCK_EN
        hold_d = lock_own && !req_own;
        if (lock_own && req_own) begin
          opd_o_d   = sel_o;
          opd_t_d   = sel_t;
          gnt_d     = own_oh;
          lat_cnt_d = '0;
          rr_ptr_d  = rr_ptr_q;
          state_d   = MUL;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lat_cnt_q <= '0;
      opd_o_q   <= '0;
      opd_t_q   <= '0;
      gnt_q     <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
`ifdef MUL_ARB_LOCK_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      opd_o_q   <= opd_o_d;
      opd_t_q   <= opd_t_d;
      gnt_q     <= gnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
`ifdef MUL_ARB_LOCK_EN
      hold_q    <= hold_d;
`endif
    end
  end

  // Array inputs are forced to 0 outside MUL so an idle array never sees stale operands.
  assign mul_o_out = (state_q == MUL) ? opd_o_q : '0;
  assign mul_t_out = (state_q == MUL) ? opd_t_q : '0;
  assign gnt       = gnt_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_dat   = rsp_dat_q;

endmodule
